// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 key event generator.
// Key indices match the bit positions of the decoder's held-key level bus.
package ps2_key_pkg;

    localparam int KEY_NUM   = 6;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_ENTER = 4;
    localparam int KEY_SPACE = 5;

    localparam int EVT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_e;

    // Event word layout: {rpt, code[2:0]}
    function automatic logic [EVT_W-1:0] make_evt(input logic rpt, input logic [2:0] code);
        return {rpt, code};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous show-ahead FIFO; head word is visible while not empty.
// A push is refused when full even if the head is popped in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             empty;
    logic             do_push, do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign do_push  = wr_valid & ~full;
    assign do_pop   = rd_ready & ~empty;
    assign rd_valid = ~empty;
    // Stale storage is masked so the head reads as zero whenever empty.
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_gen.sv
// Converts held-key levels into press and typematic repeat events, queued
// in a small FIFO through a per-key pending stage and fixed-priority arbiter.
module ps2_key_event_gen
    import ps2_key_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int DELAY_TICKS = 500,
    parameter int RATE_TICKS  = 100,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_lvl,
    output logic               evt_valid,
    output logic [EVT_W-1:0]   evt_data,
    input  logic               evt_ready,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [TW-1:0]      tick_cnt_reg;
    logic               tick;
    logic [KEY_NUM-1:0] prev_reg;
    logic [KEY_NUM-1:0] press;
    logic [KEY_NUM-1:0] evt, evt_rpt;
    logic [KEY_NUM-1:0] pend_reg, pend_next;
    logic [KEY_NUM-1:0] pend_rpt_reg, pend_rpt_next;
    logic [KEY_NUM-1:0] grant, drop, accept;
    logic               ovf_reg, ovf_next;
    logic               fifo_full;
    logic               push_req;
    logic [EVT_W-1:0]   push_data;

    assign tick  = (tick_cnt_reg == TW'(TICK_DIV - 1));
    assign press = key_lvl & ~prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_reg <= '0;
            prev_reg     <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            prev_reg     <= key_lvl;
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
            key_state_e       state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             evt_k, rpt_k;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Release takes precedence over a tick arriving in the same cycle.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (press[gi]) begin
                            state_next = ST_DELAY;
                            cnt_next   = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!key_lvl[gi]) begin
                            state_next = ST_IDLE;
                        end else if (tick) begin
                            if (cnt_reg == CNT_W'(DELAY_TICKS - 1)) begin
                                state_next = ST_REPEAT;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!key_lvl[gi]) begin
                            state_next = ST_IDLE;
                        end else if (tick) begin
                            if (cnt_reg == CNT_W'(RATE_TICKS - 1)) begin
                                cnt_next = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            always_comb begin
                evt_k = 1'b0;
                rpt_k = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        evt_k = press[gi];
                    end
                    ST_DELAY: begin
                        if (key_lvl[gi] && tick && (cnt_reg == CNT_W'(DELAY_TICKS - 1))) begin
                            evt_k = 1'b1;
                            rpt_k = 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (key_lvl[gi] && tick && (cnt_reg == CNT_W'(RATE_TICKS - 1))) begin
                            evt_k = 1'b1;
                            rpt_k = 1'b1;
                        end
                    end
                    default: begin
                        evt_k = 1'b0;
                        rpt_k = 1'b0;
                    end
                endcase
            end

            assign evt[gi]     = evt_k;
            assign evt_rpt[gi] = rpt_k;
        end
    endgenerate

    // Lowest pending index wins; nothing is granted while the FIFO is full.
    always_comb begin
        grant     = '0;
        push_req  = 1'b0;
        push_data = '0;
        if (!fifo_full) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                if (pend_reg[i] && !push_req) begin
                    push_req  = 1'b1;
                    grant[i]  = 1'b1;
                    push_data = make_evt(pend_rpt_reg[i], 3'(i));
                end
            end
        end
    end

    // A dropped event leaves the older pending entry (and its rpt flag) intact.
    assign drop      = evt & pend_reg & ~grant;
    assign accept    = evt & ~drop;
    assign pend_next = accept | (pend_reg & ~grant);

    always_comb begin
        pend_rpt_next = pend_rpt_reg;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (accept[i]) begin
                pend_rpt_next[i] = evt_rpt[i];
            end
        end
        if (|drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg     <= '0;
            pend_rpt_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            pend_rpt_reg <= pend_rpt_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign ovf = ovf_reg;

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (push_req),
        .wr_data  (push_data),
        .full     (fifo_full),
        .rd_valid (evt_valid),
        .rd_data  (evt_data),
        .rd_ready (evt_ready)
    );

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Directed bench for ps2_key_event_gen with TICK_DIV=4, DELAY=3, RATE=2, DEPTH=4.
// Accepted events are logged with the cycle index since reset release.
module tb_ps2_key_event_gen;
    import ps2_key_pkg::*;

    logic               clk;
    logic               rst;
    logic [KEY_NUM-1:0] key_lvl;
    logic               evt_valid;
    logic [EVT_W-1:0]   evt_data;
    logic               evt_ready;
    logic               ovf;
    logic               ovf_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base;
    int log_cyc[$];
    int log_dat[$];

    ps2_key_event_gen #(
        .TICK_DIV    (4),
        .DELAY_TICKS (3),
        .RATE_TICKS  (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_lvl   (key_lvl),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(int'(evt_data));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic chk_evt(input string tag, input int idx, input int exp_cyc, input int exp_dat);
        if (idx < log_cyc.size()) begin
            check({tag, "_cyc"}, log_cyc[idx], exp_cyc);
            check({tag, "_dat"}, log_dat[idx], exp_dat);
        end else begin
            check({tag, "_present"}, log_cyc.size(), idx + 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align4();
        step();
        while (cyc % 4 != 0) step();
        base = cyc;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_dat.delete();
    endtask

    initial begin
        rst       = 1'b0;
        key_lvl   = 6'($urandom);
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset state with random key levels
        steps(5);
        key_lvl = 6'($urandom);
        step();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_data", int'(evt_data), 0);
        check("rst_ovf", int'(ovf), 0);
        key_lvl = '0;
        rst     = 1'b1;
        steps(100);
        check("idle_no_events", log_cyc.size(), 0);
        check("idle_valid", int'(evt_valid), 0);

        // Short tap of up: one press event, no repeat
        evt_ready = 1'b1;
        clear_log();
        align4();
        key_lvl = 6'b000001;
        steps(5);
        key_lvl = '0;
        steps(40);
        check("tap_count", log_cyc.size(), 1);
        chk_evt("tap_e0", 0, base + 2, 'h0);

        // Hold right: press, first repeat on the third tick, then every 8 cycles
        clear_log();
        align4();
        key_lvl = 6'b001000;
        steps(58);
        key_lvl = '0;
        steps(30);
        check("hold_count", log_cyc.size(), 7);
        chk_evt("hold_e0", 0, base + 2, 'h3);
        chk_evt("hold_e1", 1, base + 13, 'hB);
        chk_evt("hold_e2", 2, base + 21, 'hB);
        chk_evt("hold_e3", 3, base + 29, 'hB);
        chk_evt("hold_e6", 6, base + 53, 'hB);
        check("hold_ovf", int'(ovf), 0);

        // Up and space together: priority order on consecutive cycles
        clear_log();
        align4();
        key_lvl = 6'b100001;
        steps(2);
        key_lvl = '0;
        steps(20);
        check("dual_count", log_cyc.size(), 2);
        chk_evt("dual_e0", 0, base + 2, 'h0);
        chk_evt("dual_e1", 1, base + 3, 'h5);
        check("dual_ovf", int'(ovf), 0);

        // Stalled consumer: FIFO fills, enter/space stay pending, repeats overflow
        evt_ready = 1'b0;
        clear_log();
        align4();
        key_lvl = 6'b000001; step();
        key_lvl = 6'b000010; step();
        key_lvl = 6'b000100; step();
        key_lvl = 6'b001000; step();
        key_lvl = 6'b010000; step();
        key_lvl = 6'b110000;
        steps(5);
        check("stall_valid", int'(evt_valid), 1);
        check("stall_head", int'(evt_data), 'h0);
        steps(4);
        check("stall_ovf_before", int'(ovf), 0);
        steps(6);
        check("stall_ovf_after", int'(ovf), 1);
        key_lvl = '0;
        steps(2);
        evt_ready = 1'b1;
        steps(10);
        check("drain_count", log_cyc.size(), 6);
        chk_evt("drain_e0", 0, base + 22, 'h0);
        chk_evt("drain_e1", 1, base + 23, 'h1);
        chk_evt("drain_e2", 2, base + 24, 'h2);
        chk_evt("drain_e3", 3, base + 25, 'h3);
        chk_evt("drain_e4", 4, base + 26, 'h4);
        chk_evt("drain_e5", 5, base + 27, 'h5);
        check("ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);

        // Reset in the middle of REPEAT while left is held
        evt_ready = 1'b0;
        clear_log();
        align4();
        key_lvl = 6'b000100;
        steps(16);
        check("pre_rst_valid", int'(evt_valid), 1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", int'(evt_valid), 0);
        check("async_rst_data", int'(evt_data), 0);
        steps(2);
        clear_log();
        rst       = 1'b1;
        evt_ready = 1'b1;
        steps(14);
        key_lvl = '0;
        steps(30);
        check("rerst_count", log_cyc.size(), 2);
        chk_evt("rerst_e0", 0, 2, 'h2);
        chk_evt("rerst_e1", 1, 13, 'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
